// File: rtl/alu_issue_stage.sv
// Decode/issue register for the ALU: decodes RV32I OP, OP-IMM, LUI and AUIPC
// into an operation plus operands and holds it behind a valid/ready handshake.

package alu_issue_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_operation_type;
endpackage

module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           in_instr_i,
   input  logic [DATA_WIDTH-1:0] in_pc_i,
   input  logic [DATA_WIDTH-1:0] in_rs1_data_i,
   input  logic [DATA_WIDTH-1:0] in_rs2_data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output alu_operation_type     out_operation_o,
   output logic [DATA_WIDTH-1:0] out_a_o,
   output logic [DATA_WIDTH-1:0] out_b_o,
   output logic [4:0]            out_rd_o,
   output logic                  out_rd_we_o,
   output logic                  out_illegal_o,
   output logic [DATA_WIDTH-1:0] out_pc_o
);

   logic [6:0]            opcode_s;
   logic [2:0]            funct3_s;
   logic [6:0]            funct7_s;
   logic [4:0]            rd_s;
   logic [DATA_WIDTH-1:0] imm_i_s;
   logic [DATA_WIDTH-1:0] shamt_s;

   alu_operation_type     raw_op_s;
   logic [DATA_WIDTH-1:0] raw_a_s;
   logic [DATA_WIDTH-1:0] raw_b_s;
   logic                  dec_illegal_s;
   alu_operation_type     dec_op_s;
   logic [DATA_WIDTH-1:0] dec_a_s;
   logic [DATA_WIDTH-1:0] dec_b_s;
   logic                  dec_rd_we_s;
   logic                  capture_s;

   logic                  valid_q, valid_d;
   alu_operation_type     op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [4:0]            rd_q, rd_d;
   logic                  rd_we_q, rd_we_d;
   logic                  illegal_q, illegal_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;

   assign opcode_s = in_instr_i[6:0];
   assign funct3_s = in_instr_i[14:12];
   assign funct7_s = in_instr_i[31:25];
   assign rd_s     = in_instr_i[11:7];
   assign imm_i_s  = {{(DATA_WIDTH-12){in_instr_i[31]}}, in_instr_i[31:20]};
   assign shamt_s  = {{(DATA_WIDTH-5){1'b0}}, in_instr_i[24:20]};

   // Instruction decode: operation, operands and legality of the incoming word.
   always_comb begin
      raw_op_s      = ALU_ADD;
      raw_a_s       = {DATA_WIDTH{1'b0}};
      raw_b_s       = {DATA_WIDTH{1'b0}};
      dec_illegal_s = 1'b0;
      case (opcode_s)
         7'b0110011: begin
            raw_a_s = in_rs1_data_i;
            raw_b_s = in_rs2_data_i;
            if (funct7_s == 7'b0000000) begin
               case (funct3_s)
                  3'b000:  raw_op_s = ALU_ADD;
                  3'b001:  raw_op_s = ALU_SLL;
                  3'b010:  raw_op_s = ALU_SLT;
                  3'b011:  raw_op_s = ALU_SLTU;
                  3'b100:  raw_op_s = ALU_XOR;
                  3'b101:  raw_op_s = ALU_SRL;
                  3'b110:  raw_op_s = ALU_OR;
                  3'b111:  raw_op_s = ALU_AND;
                  default: dec_illegal_s = 1'b1;
               endcase
            end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
               raw_op_s = ALU_SUB;
            end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b101)) begin
               raw_op_s = ALU_SRA;
            end else begin
               dec_illegal_s = 1'b1;
            end
         end
         7'b0010011: begin
            raw_a_s = in_rs1_data_i;
            raw_b_s = imm_i_s;
            case (funct3_s)
               3'b000: raw_op_s = ALU_ADD;
               3'b010: raw_op_s = ALU_SLT;
               3'b011: raw_op_s = ALU_SLTU;
               3'b100: raw_op_s = ALU_XOR;
               3'b110: raw_op_s = ALU_OR;
               3'b111: raw_op_s = ALU_AND;
               3'b001: begin
                  raw_b_s = shamt_s;
                  if (funct7_s == 7'b0000000) begin
                     raw_op_s = ALU_SLL;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               3'b101: begin
                  raw_b_s = shamt_s;
                  if (funct7_s == 7'b0000000) begin
                     raw_op_s = ALU_SRL;
                  end else if (funct7_s == 7'b0100000) begin
                     raw_op_s = ALU_SRA;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               default: dec_illegal_s = 1'b1;
            endcase
         end
         // LUI leaves the 12-bit shift to the ALU, so the upper immediate goes out unshifted.
         7'b0110111: begin
            raw_op_s = ALU_LUI;
            raw_b_s  = {{(DATA_WIDTH-20){1'b0}}, in_instr_i[31:12]};
         end
         7'b0010111: begin
            raw_op_s = ALU_ADD;
            raw_a_s  = in_pc_i;
            raw_b_s  = {in_instr_i[31:12], 12'b0};
         end
         default: dec_illegal_s = 1'b1;
      endcase
   end

   assign dec_op_s    = dec_illegal_s ? ALU_ADD : raw_op_s;
   assign dec_a_s     = dec_illegal_s ? {DATA_WIDTH{1'b0}} : raw_a_s;
   assign dec_b_s     = dec_illegal_s ? {DATA_WIDTH{1'b0}} : raw_b_s;
   assign dec_rd_we_s = !dec_illegal_s && (rd_s != 5'd0);

   assign in_ready_o = !valid_q || out_ready_i;
   assign capture_s  = in_valid_i && in_ready_o;

   // Issue register next state: flush beats capture, capture beats drain.
   always_comb begin
      valid_d   = valid_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rd_d      = rd_q;
      rd_we_d   = rd_we_q;
      illegal_d = illegal_q;
      pc_d      = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (capture_s) begin
         valid_d   = 1'b1;
         op_d      = dec_op_s;
         a_d       = dec_a_s;
         b_d       = dec_b_s;
         rd_d      = rd_s;
         rd_we_d   = dec_rd_we_s;
         illegal_d = dec_illegal_s;
         pc_d      = in_pc_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Issue register state with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_q   <= 1'b0;
         op_q      <= ALU_ADD;
         a_q       <= {DATA_WIDTH{1'b0}};
         b_q       <= {DATA_WIDTH{1'b0}};
         rd_q      <= 5'd0;
         rd_we_q   <= 1'b0;
         illegal_q <= 1'b0;
         pc_q      <= {DATA_WIDTH{1'b0}};
      end else begin
         valid_q   <= valid_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rd_q      <= rd_d;
         rd_we_q   <= rd_we_d;
         illegal_q <= illegal_d;
         pc_q      <= pc_d;
      end
   end

   assign out_valid_o     = valid_q;
   assign out_operation_o = op_q;
   assign out_a_o         = a_q;
   assign out_b_o         = b_q;
   assign out_rd_o        = rd_q;
   assign out_rd_we_o     = rd_we_q;
   assign out_illegal_o   = illegal_q;
   assign out_pc_o        = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a rule-level
// decode model and an expected-issue-register record.

module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [31:0]       in_pc;
   logic [31:0]       in_rs1;
   logic [31:0]       in_rs2;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   alu_operation_type out_op;
   logic [31:0]       out_a;
   logic [31:0]       out_b;
   logic [4:0]        out_rd;
   logic              out_rd_we;
   logic              out_illegal;
   logic [31:0]       out_pc;

   alu_issue_stage #(.DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
      .in_pc_i(in_pc), .in_rs1_data_i(in_rs1), .in_rs2_data_i(in_rs2),
      .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_operation_o(out_op), .out_a_o(out_a), .out_b_o(out_b),
      .out_rd_o(out_rd), .out_rd_we_o(out_rd_we), .out_illegal_o(out_illegal),
      .out_pc_o(out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      alu_operation_type op;
      logic [31:0]       a;
      logic [31:0]       b;
      logic [4:0]        rd;
      logic              we;
      logic              ill;
      logic [31:0]       pc;
   } rec_t;

   int checks   = 0;
   int failures = 0;

   // expected contents of the issue register
   bit   m_live  = 1'b0;
   bit   m_valid = 1'b0;
   bit   m_known = 1'b0;
   rec_t m_rec;

   alu_operation_type reg_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                      ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic rec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      rec_t r;
      logic [6:0] opc = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      logic [6:0] f7  = ins[31:25];
      logic signed [11:0] imm = ins[31:20];
      r.op = ALU_ADD; r.a = 32'd0; r.b = 32'd0; r.rd = ins[11:7]; r.ill = 1'b1; r.pc = pc;
      if (opc == 7'h33) begin
         if (f7 == 7'h00) begin
            r.ill = 1'b0; r.op = reg_tab[f3];
         end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
            r.ill = 1'b0; r.op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
         end
         if (!r.ill) begin r.a = r1; r.b = r2; end
      end else if (opc == 7'h13) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
               r.ill = 1'b0;
               r.op  = (f7 == 7'h20) ? ALU_SRA : reg_tab[f3];
               r.a   = r1;
               r.b   = 32'(ins[24:20]);
            end
         end else begin
            r.ill = 1'b0; r.op = reg_tab[f3]; r.a = r1; r.b = 32'(imm);
         end
      end else if (opc == 7'h37) begin
         r.ill = 1'b0; r.op = ALU_LUI; r.b = ins[31:12] + 32'd0;
      end else if (opc == 7'h17) begin
         r.ill = 1'b0; r.a = pc; r.b = ins[31:12] * 32'd4096;
      end
      r.we = !r.ill && (r.rd != 5'd0);
      return r;
   endfunction

   // one clock: drive, compare at negedge, advance the model at posedge
   task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic fl, input logic ordy);
      rst_n = rst; in_valid = v; in_instr = ins; in_pc = pc;
      in_rs1 = r1; in_rs2 = r2; flush = fl; out_ready = ordy;
      @(negedge clk);
      if (m_live) begin
         check_val("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
         check_val("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_known) begin
            check_val("op", 32'(out_op), 32'(m_rec.op));
            check_val("a", out_a, m_rec.a);
            check_val("b", out_b, m_rec.b);
            check_val("rd", 32'(out_rd), 32'(m_rec.rd));
            check_val("rd_we", 32'(out_rd_we), 32'(m_rec.we));
            check_val("illegal", 32'(out_illegal), 32'(m_rec.ill));
            check_val("pc", out_pc, m_rec.pc);
         end
      end
      @(posedge clk);
      if (!rst) begin
         m_live = 1'b1; m_valid = 1'b0; m_known = 1'b1;
         m_rec = '{ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0};
      end else if (fl) begin
         m_valid = 1'b0; m_known = 1'b0;
      end else if (v && (!m_valid || ordy)) begin
         m_rec = ref_decode(ins, pc, r1, r2); m_valid = 1'b1; m_known = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0; m_known = 1'b0;
      end
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      logic [6:0]  f7;
      int sel = $urandom_range(0, 9);
      int k   = $urandom_range(0, 9);
      f7 = (k < 5) ? 7'h00 : (k < 8) ? 7'h20 : 7'($urandom);
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      if (sel < 3)      w = {f7, w[24:7], 7'h33};
      else if (sel < 6) w = {f7, w[24:7], 7'h13};
      else if (sel < 7) w = {w[31:7], 7'h37};
      else if (sel < 8) w = {w[31:7], 7'h17};
      else if (sel < 9) w = 32'h0000_0000;
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
      in_rs1 = 32'd0; in_rs2 = 32'd0; flush = 1'b0; out_ready = 1'b0;

      cycle(1'b0, 1'b1, 32'h002081B3, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h002081B3, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0);
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd1);
      check_val("rst_op", 32'(out_op), 32'(ALU_ADD));

      cycle(1'b1, 1'b1, 32'h002081B3, 32'h40, 32'd5, 32'd7, 1'b0, 1'b1);
      check_val("add_valid", 32'(out_valid), 32'd1);
      check_val("add_ab", {out_a[15:0], out_b[15:0]}, {16'd5, 16'd7});
      check_val("add_rd", {27'd0, out_rd}, 32'd3);

      cycle(1'b1, 1'b1, 32'h407302B3, 32'h44, 32'd20, 32'd3, 1'b0, 1'b1);
      check_val("sub_op", 32'(out_op), 32'(ALU_SUB));
      check_val("sub_rd", {27'd0, out_rd}, 32'd5);
      cycle(1'b1, 1'b1, 32'h40415093, 32'h48, 32'hFFFF_FFF0, 32'd9, 1'b0, 1'b1);
      check_val("srai_op", 32'(out_op), 32'(ALU_SRA));
      check_val("srai_b", out_b, 32'd4);
      check_val("srai_rd", {27'd0, out_rd}, 32'd1);
      check_val("srai_valid", 32'(out_valid), 32'd1);

      cycle(1'b1, 1'b1, 32'hFFF00093, 32'h4C, 32'd0, 32'd0, 1'b0, 1'b1);
      check_val("addi_b", out_b, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b1, 32'h12345137, 32'h50, 32'd1, 32'd2, 1'b0, 1'b1);
      check_val("lui_op", 32'(out_op), 32'(ALU_LUI));
      check_val("lui_ab", out_a | out_b, 32'h0001_2345);
      cycle(1'b1, 1'b1, 32'h00001197, 32'h100, 32'd1, 32'd2, 1'b0, 1'b1);
      check_val("auipc_a", out_a, 32'h100);
      check_val("auipc_b", out_b, 32'h1000);

      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 32'h00A00513, 32'h104, 32'd0, 32'd0, 1'b0, 1'b0);
         check_val("stall_ready", 32'(in_ready), 32'd0);
         check_val("stall_pc", out_pc, 32'h100);
      end
      cycle(1'b1, 1'b1, 32'h00A00513, 32'h104, 32'd0, 32'd0, 1'b0, 1'b1);
      check_val("resume_b", out_b, 32'd10);
      check_val("resume_pc", out_pc, 32'h104);

      cycle(1'b1, 1'b1, 32'h0000_0000, 32'h108, 32'd3, 32'd4, 1'b0, 1'b1);
      check_val("ill_flag", 32'(out_illegal), 32'd1);
      check_val("ill_we", 32'(out_rd_we), 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h002081B3, 32'h10C, 32'd1, 32'd1, 1'b1, 1'b0);
      check_val("flush_valid", 32'(out_valid), 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
